// File: rtl/mbist_pkg.sv
// -----------------------------------------------------------------------------
// mbist_pkg
// Shared types and constants for the March C- MBIST controller.
//   op_e          : memory operation kinds (w0, w1, r0, r1)
//   march_elem_t  : one march element (direction, op count, up to two ops)
//   MARCH_C_MINUS : the six elements M0..M5 of March C-
//   state_e       : controller FSM states
//   op_data_bit   : background bit of an op; the data word is this bit
//                   replicated across the word (all-0 / all-1)
// -----------------------------------------------------------------------------
package mbist_pkg;

  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    R0 = 2'd2,
    R1 = 2'd3
  } op_e;

  // dir: 1 = ascending address order, 0 = descending.
  // op1 is only meaningful when n_ops == 2.
  typedef struct packed {
    logic       dir;
    logic [1:0] n_ops;
    op_e        op0;
    op_e        op1;
  } march_elem_t;

  localparam int N_ELEMS = 6;

  localparam march_elem_t MARCH_C_MINUS [N_ELEMS] = '{
    '{dir: 1'b1, n_ops: 2'd1, op0: W0, op1: W0},  // M0 up   (w0)
    '{dir: 1'b1, n_ops: 2'd2, op0: R0, op1: W1},  // M1 up   (r0,w1)
    '{dir: 1'b1, n_ops: 2'd2, op0: R1, op1: W0},  // M2 up   (r1,w0)
    '{dir: 1'b0, n_ops: 2'd2, op0: R0, op1: W1},  // M3 down (r0,w1)
    '{dir: 1'b0, n_ops: 2'd2, op0: R1, op1: W0},  // M4 down (r1,w0)
    '{dir: 1'b1, n_ops: 2'd1, op0: R0, op1: R0}   // M5 up   (r0)
  };

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Background value carried by an op: 1 for w1/r1, 0 for w0/r0.
  function automatic logic op_data_bit(input op_e op);
    return (op == W1) || (op == R1);
  endfunction

  function automatic logic op_is_read(input op_e op);
    return (op == R0) || (op == R1);
  endfunction

  function automatic op_e elem_op(input march_elem_t e, input logic k);
    return k ? e.op1 : e.op0;
  endfunction

endpackage

// File: rtl/counter.sv
// -----------------------------------------------------------------------------
// counter
// Up/down loadable counter used as the MBIST address generator.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset (q -> 0)
//   ld    : load d_in (has priority over cen)
//   d_in  : load value
//   u_d   : count direction, 1 = up, 0 = down
//   cen   : count enable
//   q     : counter value
//   cout  : carry/borrow out, high when counting past the end of the range
// -----------------------------------------------------------------------------
module counter #(
  parameter int length = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld,
  input  logic [length-1:0] d_in,
  input  logic              u_d,
  input  logic              cen,
  output logic [length-1:0] q,
  output logic              cout
);

  logic [length-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (ld) begin
      r_q <= d_in;
    end else if (cen) begin
      r_q <= u_d ? (r_q + 1'b1) : (r_q - 1'b1);
    end
  end

  assign q    = r_q;
  assign cout = cen & (u_d ? (&r_q) : ~(|r_q));

endmodule

// File: rtl/mbist_march_ctrl.sv
// -----------------------------------------------------------------------------
// mbist_march_ctrl
// March C- sequencer for one synchronous single-port SRAM.
//   clk, rst_n      : clock / synchronous active-low reset
//   start           : 1-cycle run request, only looked at in IDLE
//   mem_addr        : address (counter value in RUN, else 0)
//   mem_we, mem_re  : 1-cycle write / read strobes, never both high
//   mem_wdata       : all-0 / all-1 background, 0 when not writing
//   mem_rdata       : read data
//   busy            : high from the first LOAD cycle through DRAIN
//   done            : 1-cycle completion pulse
//   fail            : sticky mismatch flag, cleared on accepted start
//   fail_addr/elem  : address and element of the first mismatch
//   fail_cnt        : saturating mismatch count
//   dbg_state       : current FSM state
//   dbg_cout        : address counter carry (observation only)
//
// Handshake: start is a single-cycle request with no ready; it is taken
// only when the FSM is in IDLE and dropped otherwise. The memory returns
// mem_rdata exactly one cycle after mem_re, with no backpressure.
// -----------------------------------------------------------------------------
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [7:0]        fail_cnt,
  output logic [2:0]        dbg_state,
  output logic              dbg_cout
);

  state_e            r_state, w_state_nxt;
  logic [2:0]        r_elem;
  logic              r_k;

  march_elem_t       w_elem;
  op_e               w_op;
  logic              w_last_op, w_term;
  logic              w_ld, w_cen, w_wr, w_rd;
  logic [ADDR_W-1:0] w_q, w_d_in;
  logic              w_cout;

  // One-deep read compare pipeline.
  logic              r_cmp_vld;
  logic [DATA_W-1:0] r_cmp_exp;
  logic [ADDR_W-1:0] r_cmp_addr;
  logic [2:0]        r_cmp_elem;

  logic              r_fail;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [2:0]        r_fail_elem;
  logic [7:0]        r_fail_cnt;

  assign w_elem    = MARCH_C_MINUS[r_elem];
  assign w_op      = elem_op(w_elem, r_k);
  assign w_last_op = ({1'b0, r_k} == (w_elem.n_ops - 2'd1));
  // Terminal address is checked here rather than via cout so the counter
  // never steps past the end of the array.
  assign w_term    = w_elem.dir ? (w_q == '1) : (w_q == '0);
  assign w_d_in    = w_elem.dir ? '0 : '1;

  counter #(.length(ADDR_W)) u_addr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (w_ld),
    .d_in  (w_d_in),
    .u_d   (w_elem.dir),
    .cen   (w_cen),
    .q     (w_q),
    .cout  (w_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ld        = 1'b0;
    w_cen       = 1'b0;
    w_wr        = 1'b0;
    w_rd        = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_ld        = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_rd = op_is_read(w_op);
        w_wr = ~op_is_read(w_op);
        if (w_last_op) begin
          if (w_term) begin
            w_state_nxt = (r_elem == 3'd5) ? S_DRAIN : S_LOAD;
          end else begin
            w_cen = 1'b1;
          end
        end
      end
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_elem      <= 3'd0;
      r_k         <= 1'b0;
      r_cmp_vld   <= 1'b0;
      r_cmp_exp   <= '0;
      r_cmp_addr  <= '0;
      r_cmp_elem  <= 3'd0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= 3'd0;
      r_fail_cnt  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_LOAD) begin
        r_k <= 1'b0;
      end else if (r_state == S_RUN) begin
        if (w_last_op) begin
          r_k <= 1'b0;
          if (w_term && (r_elem != 3'd5)) r_elem <= r_elem + 3'd1;
        end else begin
          r_k <= 1'b1;
        end
      end

      r_cmp_vld <= w_rd;
      if (w_rd) begin
        r_cmp_exp  <= {DATA_W{op_data_bit(w_op)}};
        r_cmp_addr <= w_q;
        r_cmp_elem <= r_elem;
      end

      if (r_cmp_vld && (mem_rdata != r_cmp_exp)) begin
        r_fail <= 1'b1;
        if (r_fail_cnt != 8'hFF) r_fail_cnt <= r_fail_cnt + 8'd1;
        if (!r_fail) begin
          r_fail_addr <= r_cmp_addr;
          r_fail_elem <= r_cmp_elem;
        end
      end

      // No compare can be pending in IDLE, so the clear never collides
      // with a mismatch update.
      if ((r_state == S_IDLE) && start) begin
        r_elem      <= 3'd0;
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_elem <= 3'd0;
        r_fail_cnt  <= 8'd0;
      end
    end
  end

  assign mem_addr  = (r_state == S_RUN) ? w_q : '0;
  assign mem_we    = w_wr;
  assign mem_re    = w_rd;
  assign mem_wdata = w_wr ? {DATA_W{op_data_bit(w_op)}} : '0;
  assign busy      = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign fail      = r_fail;
  assign fail_addr = r_fail_addr;
  assign fail_elem = r_fail_elem;
  assign fail_cnt  = r_fail_cnt;
  assign dbg_state = r_state;
  assign dbg_cout  = w_cout;

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
March C- sequencer for MBIST, sitting between the BIST top and one synchronous single-port SRAM.
- Owns one instance of the team's up/down loadable address counter (`counter`, length=ADDR_W) and drives its ld/d_in/u_d/cen.
- Issues memory read/write ops, compares read data against the expected background and reports pass/fail with first-failure diagnostics.
- Algorithm: M0 ⇑(w0); M1 ⇑(r0,w1); M2 ⇑(r1,w0); M3 ⇓(r0,w1); M4 ⇓(r1,w0); M5 ⇑(r0).

Parameters:
ADDR_W, 10, address width and counter length; N = 2**ADDR_W words
DATA_W, 8, memory word width; "0" = all-zeros word, "1" = all-ones word

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  1-cycle request to run March C-; sampled only in IDLE
mem_addr  out  ADDR_W  memory address; counter q in RUN, else 0
mem_we  out  1  write strobe, 1 cycle per write op
mem_re  out  1  read strobe, 1 cycle per read op
mem_wdata  out  DATA_W  write data (all-0 / all-1); 0 when mem_we=0
mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_re
busy  out  1  high from first LOAD cycle through DRAIN
done  out  1  1-cycle pulse when the run completes
fail  out  1  sticky mismatch flag; cleared on accepted start
fail_addr  out  ADDR_W  address of first mismatch
fail_elem  out  3  element index (0..5) of first mismatch
fail_cnt  out  8  mismatch count, saturates at 255

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE.
  - All outputs 0: mem_addr, mem_we, mem_re, mem_wdata, busy, done, fail, fail_addr, fail_elem, fail_cnt.
  - Pending compare discarded; counter content don't-care.
- Reset mid-run aborts immediately; no done pulse.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> LOAD with elem=0.
  - Accepting start clears fail/fail_addr/fail_elem/fail_cnt.
- LOAD (1 cycle):
  - Counter ld=1, d_in = 0 for ⇑ elements or N-1 for ⇓, u_d = direction (1=up), cen=0.
  - op index k=0; mem_we=mem_re=0.
  - Next state: RUN.
- RUN (1 cycle per op):
  - Issue op k of current element at q; op kinds are w0, w1, r0, r1.
  - Counter cen=1 only on the element's last op, stepping in the element's direction; otherwise k++.
- End of element: last op at terminal address (N-1 for ⇑, 0 for ⇓).
  - Detected by comparing q to the terminal address inside the controller; counter cout is not used.
  - Counter cen is held 0 on the terminal op, so no wrap occurs.
  - Next state: elem<5 -> LOAD with elem+1; elem==5 -> DRAIN.
- DRAIN (1 cycle): completes the final read compare. Next state: DONE.
- DONE (1 cycle): done=1, busy=0. Next state: IDLE.
- Read compare pipeline:
  - On a read, register expected word, address and elem.
  - Next cycle, compare mem_rdata to the expected word.
  - On mismatch: fail=1, fail_cnt += 1 (saturating at 255). If this is the first mismatch of the run, also latch fail_addr and fail_elem.
- Ops per address per element: 1, 2, 2, 2, 2, 1 (M0..M5); total 10N ops.
- Run length: busy high for exactly 10N+7 cycles (6 LOAD + 10N RUN + 1 DRAIN); done in the following cycle.
- start while busy or in DONE: ignored.
- mem_we and mem_re are never high together; at most one op per cycle.
- Counter ld and cen are never asserted together.

Decomposition:
- Package mbist_pkg:
  - op_e enum (W0, W1, R0, R1).
  - march_elem_t struct (dir, n_ops, ops[2]).
  - Localparam MARCH_C_MINUS array of 6 elements.
  - state_e enum.
  - Function for the all-0/all-1 data word.
- Sub-module: existing `counter` (length=ADDR_W) as the address generator, instantiated inside mbist_march_ctrl.
- Memory model and fault injection are bench-only.

Test Plan:
- ADDR_W=3 (N=8), fault-free 1-cycle-latency RAM, start pulse -> busy high exactly 87 cycles, done pulse once, fail=0, fail_cnt=0; op log shows 80 ops in March C- order.
- ADDR_W=3, addr 5 bit0 stuck-at-0 -> first mismatch is r1 in M2: fail=1, fail_addr=5, fail_elem=2; fail_cnt=2 (M2 r1 and M4 r1); done still pulses.
- ADDR_W=3 direction check -> first RUN address after LOAD is 0 for M0–M2 and M5, 7 for M3–M4; final ops of M3/M4 at address 0; no address outside 0..7.
- ADDR_W=6, RAM always returns inverted data -> 320 reads, fail_cnt saturates at 255; fail_addr=0, fail_elem=1.
- Pulse start again mid-run, then assert rst_n=0 for 1 cycle mid-M3 -> second start ignored (op count unchanged); after reset: all outputs 0, state IDLE, no done pulse.
- Run a clean test after a failing run -> accepted start clears fail, fail_cnt, fail_addr and fail_elem to 0; run ends with fail=0.
